battleship_turn_ctrl: RTL and testbench
=======================================

// Module: battleship_turn_ctrl
// PURPOSE
//  Game sequencer that drives the board/VGA block's control inputs.
//  - Inputs: five debounced push-buttons.
//  - Outputs: cursor, place/fire pulses, phase, active player, view select and
//    hand-off blanking.
//  - Keeps shadow ship/shot maps, so it rejects duplicate placements and
//    repeat shots, counts hits and declares a winner.
// PARAMETERS
//  GRID_N       9            board edge length; cursor range 0..GRID_N-1
//  SHIPS        5            ship cells each player places; hits needed to win
//  BLANK_CYCLES 100_000_000  clk cycles of blank screen per hand-off (>=1)
// PORTS
//  clk           in   1  system clock (100 MHz)
//  reset         in   1  synchronous, active-high
//  btn_up        in   1  debounced level, active high
//  btn_down      in   1  debounced level, active high
//  btn_left      in   1  debounced level, active high
//  btn_right     in   1  debounced level, active high
//  btn_center    in   1  debounced level, active high
//  sel_row       out  4  cursor row, registered
//  sel_col       out  4  cursor column, registered
//  place_pulse   out  1  1-cycle place strobe
//  fire_pulse    out  1  1-cycle fire strobe
//  placing_phase out  1  1 while ships are being placed
//  active_player out  1  0 = P1, 1 = P2
//  player_view   out  1  board shown: 0 = P1 grid, 1 = P2 grid
//  show_blank    out  1  blank screen during hand-off
//  game_over     out  1  sticky until reset
//  winner        out  1  winning player; valid when game_over = 1
// BEHAVIOUR
//  Reset: state PLACE; sel 0,0; pulses 0; placing_phase 1; active_player 0;
//   player_view 0; show_blank 0; game_over 0; winner 0.
//   Clear the ship maps, shot maps, placement counts and hit counts.
//  Button edges: edge = btn & ~btn_q; btn_q is registered every cycle.
//  Cursor: accepts arrow edges only in PLACE or FIRE.
//   up: row-1; down: row+1; left: col-1; right: col+1.
//   Wrap: 0 <-> GRID_N-1.
//   up+down edges in the same cycle: no row change. left+right: no col change.
//   A center edge in the same cycle takes priority; arrow edges are dropped.
//  States: PLACE, ACT_PLACE, FIRE, ACT_FIRE, HANDOFF, OVER.
//  PLACE, center edge:
//   - Cell already holds own ship: ignored, no pulse.
//   - Otherwise: set the ship bit and go to ACT_PLACE.
//  ACT_PLACE: exactly one cycle. place_pulse = 1.
//   sel, active_player and placing_phase stay unchanged during the pulse.
//   Next state:
//   - count < SHIPS: back to PLACE.
//   - P1 done: active_player <- 1, HANDOFF, target PLACE.
//   - P2 done: active_player <- 0, HANDOFF, target FIRE.
//  FIRE, center edge:
//   - Cell already shot by the active player: ignored.
//   - Otherwise: mark the shot. If the opponent has a ship there, hits[p]++.
//     Go to ACT_FIRE.
//  ACT_FIRE: one cycle. fire_pulse = 1 with outputs held.
//   - hits[p] == SHIPS: OVER, winner <- p, game_over <- 1.
//   - Otherwise: toggle active_player, HANDOFF, target FIRE.
//  HANDOFF: show_blank = 1 for exactly BLANK_CYCLES cycles.
//   Buttons are ignored. Cursor resets to 0,0.
//   Then enter the target state with show_blank = 0.
//  placing_phase = 1 in PLACE, ACT_PLACE and HANDOFF->PLACE; 0 otherwise.
//  player_view:
//   - active_player in PLACE and ACT_PLACE.
//   - ~active_player in FIRE and ACT_FIRE (the target board).
//   - During HANDOFF: value for the target state.
//   - In OVER: ~winner.
//  OVER: no pulses, show_blank 0, all buttons ignored until reset.
//  Latency: center edge sampled at cycle T gives the pulse at T+1.
//   The next button is accepted from T+2 if no HANDOFF occurs.
//  Reset mid-hand-off or mid-pulse: aborts immediately to the reset state.
//   No pulse in the cycle after reset.
// TESTING
//  1. Reset, then a 3x down and 1x left edge -> sel_row 3, sel_col 8;
//     up at row 0 -> row 8.
//  2. P1 presses center at (3,8) -> place_pulse high 1 cycle at T+1,
//     active_player 0, placing_phase 1. A repeat at (3,8) -> no pulse.
//  3. P1 places SHIPS cells, BLANK_CYCLES=4 -> show_blank high 4 cycles,
//     then active_player 1, sel 0,0, player_view 1.
//  4. After P2 placement -> placing_phase 0, active_player 0, player_view 1.
//     P1 fires at (0,0) -> fire_pulse 1 cycle, then hand-off to P2.
//  5. P1 hits all 5 P2 ships -> game_over 1, winner 0, no hand-off.
//     Later buttons -> no pulses.
//  6. reset asserted during HANDOFF and during ACT_FIRE -> all outputs at
//     reset values the next cycle; counters cleared.

Source files
------------

// File: rtl/battleship_turn_ctrl.sv
// Two-player battleship turn sequencer: cursor, place/fire strobes, hand-off blanking,
// and shadow ship/shot maps used to reject repeats, count hits and pick the winner.
module battleship_turn_ctrl #(
    parameter int unsigned GRID_N       = 9,
    parameter int unsigned SHIPS        = 5,
    parameter int unsigned BLANK_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    input  logic       btn_center_i,
    output logic [3:0] sel_row_o,
    output logic [3:0] sel_col_o,
    output logic       place_pulse_o,
    output logic       fire_pulse_o,
    output logic       placing_phase_o,
    output logic       active_player_o,
    output logic       player_view_o,
    output logic       show_blank_o,
    output logic       game_over_o,
    output logic       winner_o
);

    localparam int unsigned Cells  = GRID_N * GRID_N;
    localparam int unsigned CellW  = $clog2(Cells);
    localparam int unsigned CntW   = $clog2(SHIPS + 1);
    localparam int unsigned BlankW = $clog2(BLANK_CYCLES + 1);

    localparam logic [3:0]        MaxIdx    = 4'(GRID_N - 1);
    localparam logic [CntW-1:0]   ShipsC    = CntW'(SHIPS);
    localparam logic [BlankW-1:0] BlankLast = BlankW'(BLANK_CYCLES - 1);

    typedef enum logic [2:0] {
        StPlace,
        StActPlace,
        StFire,
        StActFire,
        StHandoff,
        StOver
    } state_t;

    state_t state_q, target_q;

    logic [3:0]        sel_row_q, sel_col_q;
    logic [3:0]        row_d, col_d;
    logic              place_pulse_q, fire_pulse_q;
    logic              placing_phase_q, active_player_q, player_view_q;
    logic              show_blank_q, game_over_q, winner_q;
    logic [BlankW-1:0] blank_cnt_q;

    logic [Cells-1:0]  ship_q [2];
    logic [Cells-1:0]  shot_q [2];
    logic [CntW-1:0]   place_cnt_q [2];
    logic [CntW-1:0]   hits_q [2];

    // Button vectors are ordered {center, right, left, down, up}.
    logic [4:0]        btn, btn_q, btn_rise;
    logic [CellW-1:0]  cell_idx;
    logic              own_ship, own_shot, opp_ship;

    assign btn      = {btn_center_i, btn_right_i, btn_left_i, btn_down_i, btn_up_i};
    assign btn_rise = btn & ~btn_q;
    assign cell_idx = CellW'(sel_row_q) * CellW'(GRID_N) + CellW'(sel_col_q);
    assign own_ship = ship_q[active_player_q][cell_idx];
    assign own_shot = shot_q[active_player_q][cell_idx];
    assign opp_ship = ship_q[~active_player_q][cell_idx];

    // Opposing arrows in the same cycle cancel; edges wrap 0 <-> GRID_N-1.
    always_comb begin
        row_d = sel_row_q;
        col_d = sel_col_q;
        if (btn_rise[0] && !btn_rise[1]) begin
            row_d = (sel_row_q == 4'd0) ? MaxIdx : sel_row_q - 4'd1;
        end else if (btn_rise[1] && !btn_rise[0]) begin
            row_d = (sel_row_q == MaxIdx) ? 4'd0 : sel_row_q + 4'd1;
        end
        if (btn_rise[2] && !btn_rise[3]) begin
            col_d = (sel_col_q == 4'd0) ? MaxIdx : sel_col_q - 4'd1;
        end else if (btn_rise[3] && !btn_rise[2]) begin
            col_d = (sel_col_q == MaxIdx) ? 4'd0 : sel_col_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        btn_q <= btn;
        if (reset) begin
            state_q         <= StPlace;
            target_q        <= StPlace;
            sel_row_q       <= 4'd0;
            sel_col_q       <= 4'd0;
            place_pulse_q   <= 1'b0;
            fire_pulse_q    <= 1'b0;
            placing_phase_q <= 1'b1;
            active_player_q <= 1'b0;
            player_view_q   <= 1'b0;
            show_blank_q    <= 1'b0;
            game_over_q     <= 1'b0;
            winner_q        <= 1'b0;
            blank_cnt_q     <= '0;
            for (int p = 0; p < 2; p++) begin
                ship_q[p]      <= '0;
                shot_q[p]      <= '0;
                place_cnt_q[p] <= '0;
                hits_q[p]      <= '0;
            end
        end else begin
            place_pulse_q <= 1'b0;
            fire_pulse_q  <= 1'b0;
            case (state_q)
                StPlace: begin
                    if (btn_rise[4]) begin
                        if (!own_ship) begin
                            ship_q[active_player_q][cell_idx] <= 1'b1;
                            place_cnt_q[active_player_q] <=
                                place_cnt_q[active_player_q] + CntW'(1);
                            place_pulse_q <= 1'b1;
                            state_q       <= StActPlace;
                        end
                    end else begin
                        sel_row_q <= row_d;
                        sel_col_q <= col_d;
                    end
                end
                StActPlace: begin
                    if (place_cnt_q[active_player_q] < ShipsC) begin
                        state_q <= StPlace;
                    end else begin
                        active_player_q <= ~active_player_q;
                        target_q        <= active_player_q ? StFire : StPlace;
                        // Still placing only when P1 just finished.
                        placing_phase_q <= ~active_player_q;
                        // Either P2 places on its own grid or P1 aims at P2's grid.
                        player_view_q   <= 1'b1;
                        show_blank_q    <= 1'b1;
                        blank_cnt_q     <= BlankLast;
                        sel_row_q       <= 4'd0;
                        sel_col_q       <= 4'd0;
                        state_q         <= StHandoff;
                    end
                end
                StFire: begin
                    if (btn_rise[4]) begin
                        if (!own_shot) begin
                            shot_q[active_player_q][cell_idx] <= 1'b1;
                            if (opp_ship) begin
                                hits_q[active_player_q] <= hits_q[active_player_q] + CntW'(1);
                            end
                            fire_pulse_q <= 1'b1;
                            state_q      <= StActFire;
                        end
                    end else begin
                        sel_row_q <= row_d;
                        sel_col_q <= col_d;
                    end
                end
                StActFire: begin
                    if (hits_q[active_player_q] == ShipsC) begin
                        winner_q      <= active_player_q;
                        game_over_q   <= 1'b1;
                        player_view_q <= ~active_player_q;
                        state_q       <= StOver;
                    end else begin
                        active_player_q <= ~active_player_q;
                        // Next shooter aims at the board of the player who just fired.
                        player_view_q   <= active_player_q;
                        target_q        <= StFire;
                        show_blank_q    <= 1'b1;
                        blank_cnt_q     <= BlankLast;
                        sel_row_q       <= 4'd0;
                        sel_col_q       <= 4'd0;
                        state_q         <= StHandoff;
                    end
                end
                StHandoff: begin
                    if (blank_cnt_q == '0) begin
                        show_blank_q <= 1'b0;
                        state_q      <= target_q;
                    end else begin
                        blank_cnt_q <= blank_cnt_q - BlankW'(1);
                    end
                end
                StOver: begin
                end
                default: state_q <= StPlace;
            endcase
        end
    end

    assign sel_row_o       = sel_row_q;
    assign sel_col_o       = sel_col_q;
    assign place_pulse_o   = place_pulse_q;
    assign fire_pulse_o    = fire_pulse_q;
    assign placing_phase_o = placing_phase_q;
    assign active_player_o = active_player_q;
    assign player_view_o   = player_view_q;
    assign show_blank_o    = show_blank_q;
    assign game_over_o     = game_over_q;
    assign winner_o        = winner_q;

endmodule

// File: tb/tb_battleship_turn_ctrl.sv
// Bench for battleship_turn_ctrl: fixed vector table, directed game sequences and a
// randomized game checked against a turn-level game model.
module tb_battleship_turn_ctrl;

    localparam int GRID  = 9;
    localparam int SHIPS = 5;
    localparam int BLANK = 4;

    localparam logic [4:0] U = 5'b00001;
    localparam logic [4:0] D = 5'b00010;
    localparam logic [4:0] L = 5'b00100;
    localparam logic [4:0] R = 5'b01000;
    localparam logic [4:0] C = 5'b10000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] btns = 5'b0;
    logic [3:0] sel_row, sel_col;
    logic       place_pulse, fire_pulse, placing_phase, active_player;
    logic       player_view, show_blank, game_over, winner;

    int n_cmp = 0;
    int n_err = 0;

    // Game model: phase 0 = placing, 1 = firing, 2 = over.
    int          m_row, m_col, m_player, m_phase, m_winner;
    int          m_placed [2];
    int          m_hits [2];
    bit [GRID*GRID-1:0] m_ship [2];
    bit [GRID*GRID-1:0] m_shot [2];

    typedef struct packed {
        logic [4:0] m;
        logic [3:0] row;
        logic [3:0] col;
        logic       place;
    } vec_t;

    vec_t vecs [14];

    battleship_turn_ctrl #(
        .GRID_N      (GRID),
        .SHIPS       (SHIPS),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_up_i       (btns[0]),
        .btn_down_i     (btns[1]),
        .btn_left_i     (btns[2]),
        .btn_right_i    (btns[3]),
        .btn_center_i   (btns[4]),
        .sel_row_o      (sel_row),
        .sel_col_o      (sel_col),
        .place_pulse_o  (place_pulse),
        .fire_pulse_o   (fire_pulse),
        .placing_phase_o(placing_phase),
        .active_player_o(active_player),
        .player_view_o  (player_view),
        .show_blank_o   (show_blank),
        .game_over_o    (game_over),
        .winner_o       (winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_row = 0; m_col = 0; m_player = 0; m_phase = 0; m_winner = 0;
        for (int p = 0; p < 2; p++) begin
            m_placed[p] = 0; m_hits[p] = 0; m_ship[p] = '0; m_shot[p] = '0;
        end
    endfunction

    function automatic void model_step(input logic [4:0] m, output bit pl, output bit fi,
                                       output bit ho);
        int idx, opp;
        pl = 0; fi = 0; ho = 0;
        if (m_phase == 2) return;
        idx = m_row * GRID + m_col;
        opp = 1 - m_player;
        if (m[4]) begin
            if (m_phase == 0 && !m_ship[m_player][idx]) begin
                m_ship[m_player][idx] = 1'b1;
                m_placed[m_player]++;
                pl = 1;
                if (m_placed[m_player] == SHIPS) begin
                    ho = 1;
                    if (m_player == 1) m_phase = 1;
                    m_player = opp; m_row = 0; m_col = 0;
                end
            end else if (m_phase == 1 && !m_shot[m_player][idx]) begin
                m_shot[m_player][idx] = 1'b1;
                fi = 1;
                if (m_ship[opp][idx]) m_hits[m_player]++;
                if (m_hits[m_player] == SHIPS) begin
                    m_phase = 2; m_winner = m_player;
                end else begin
                    ho = 1; m_player = opp; m_row = 0; m_col = 0;
                end
            end
        end else begin
            m_row = (m_row + GRID + int'(m[1]) - int'(m[0])) % GRID;
            m_col = (m_col + GRID + int'(m[3]) - int'(m[2])) % GRID;
        end
    endfunction

    // One-cycle press; returns at the negedge of the cycle where a strobe would show.
    task automatic press(input logic [4:0] m);
        @(negedge clk); btns = m;
        @(negedge clk); btns = 5'b0;
    endtask

    task automatic chk_state();
        int v;
        v = (m_phase == 0) ? m_player : (m_phase == 1) ? 1 - m_player : 1 - m_winner;
        chk("sel_row", sel_row, m_row);
        chk("sel_col", sel_col, m_col);
        chk("active_player", active_player, m_player);
        chk("placing_phase", placing_phase, int'(m_phase == 0));
        chk("player_view", player_view, v);
        chk("game_over", game_over, int'(m_phase == 2));
        if (m_phase == 2) chk("winner", winner, m_winner);
        chk("show_blank", show_blank, 0);
    endtask

    task automatic do_press(input logic [4:0] m);
        bit pl, fi, ho;
        int pre_p, pre_ph, n;
        pre_p = m_player;
        pre_ph = int'(m_phase == 0);
        model_step(m, pl, fi, ho);
        press(m);
        chk("place_pulse", place_pulse, int'(pl));
        chk("fire_pulse", fire_pulse, int'(fi));
        if (pl || fi) begin
            chk("pulse_hold_player", active_player, pre_p);
            chk("pulse_hold_phase", placing_phase, pre_ph);
        end
        @(negedge clk);
        n = 0;
        while (show_blank && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("blank_len", n, ho ? BLANK : 0);
        chk_state();
    endtask

    task automatic goto(input int r, input int c);
        for (int k = 0; k < 2 * GRID && m_row != r; k++) do_press(D);
        for (int k = 0; k < 2 * GRID && m_col != c; k++) do_press(R);
    endtask

    task automatic hit(input int r, input int c);
        goto(r, c);
        do_press(C);
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; btns = 5'b0;
        @(negedge clk);
        chk("rst_sel_row", sel_row, 0);
        chk("rst_sel_col", sel_col, 0);
        chk("rst_place_pulse", place_pulse, 0);
        chk("rst_fire_pulse", fire_pulse, 0);
        chk("rst_placing_phase", placing_phase, 1);
        chk("rst_active_player", active_player, 0);
        chk("rst_player_view", player_view, 0);
        chk("rst_show_blank", show_blank, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_winner", winner, 0);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] rm;
        vecs[0]  = '{D, 4'd1, 4'd0, 1'b0};
        vecs[1]  = '{D, 4'd2, 4'd0, 1'b0};
        vecs[2]  = '{D, 4'd3, 4'd0, 1'b0};
        vecs[3]  = '{L, 4'd3, 4'd8, 1'b0};
        vecs[4]  = '{U | D, 4'd3, 4'd8, 1'b0};
        vecs[5]  = '{L | R, 4'd3, 4'd8, 1'b0};
        vecs[6]  = '{C | U, 4'd3, 4'd8, 1'b1};
        vecs[7]  = '{C, 4'd3, 4'd8, 1'b0};
        vecs[8]  = '{R, 4'd3, 4'd0, 1'b0};
        vecs[9]  = '{U, 4'd2, 4'd0, 1'b0};
        vecs[10] = '{U, 4'd1, 4'd0, 1'b0};
        vecs[11] = '{U, 4'd0, 4'd0, 1'b0};
        vecs[12] = '{U, 4'd8, 4'd0, 1'b0};
        vecs[13] = '{R | D, 4'd0, 4'd1, 1'b0};

        do_reset();

        // Cursor movement, wrap, cancellation and duplicate placement.
        for (int i = 0; i < 14; i++) begin
            press(vecs[i].m);
            chk($sformatf("vec%0d_place", i), place_pulse, vecs[i].place);
            chk($sformatf("vec%0d_row", i), sel_row, vecs[i].row);
            chk($sformatf("vec%0d_col", i), sel_col, vecs[i].col);
            chk($sformatf("vec%0d_player", i), active_player, 0);
            chk($sformatf("vec%0d_phase", i), placing_phase, 1);
            @(negedge clk);
        end

        // Directed full game: P1 ships on row 0, P2 ships on row 1, P1 wins.
        do_reset();
        for (int c = 0; c < SHIPS; c++) hit(0, c);
        for (int c = 0; c < SHIPS; c++) hit(1, c);
        hit(0, 0);
        hit(0, 0);
        hit(1, 0);
        hit(5, 5);
        hit(1, 0);
        hit(1, 1);
        hit(5, 6);
        hit(1, 2);
        hit(5, 7);
        hit(1, 3);
        hit(5, 8);
        hit(1, 4);
        chk("game_won", game_over, 1);
        chk("winner_p1", winner, 0);
        do_press(C);
        do_press(U);
        do_press(C | R);

        // Reset in the middle of a hand-off blanking period.
        do_reset();
        for (int c = 0; c < SHIPS - 1; c++) hit(0, c);
        goto(0, SHIPS - 1);
        press(C);
        chk("last_place_pulse", place_pulse, 1);
        @(negedge clk);
        chk("handoff_blank", show_blank, 1);
        @(negedge clk);
        do_reset();

        // Ship map is cleared: the same cell is accepted again, then reset during ACT_FIRE.
        do_press(C);
        for (int c = 0; c < SHIPS; c++) hit(0, c);
        for (int c = 0; c < SHIPS; c++) hit(1, c);
        press(C);
        chk("act_fire_pulse", fire_pulse, 1);
        do_reset();
        @(negedge clk);
        chk("post_reset_fire", fire_pulse, 0);
        chk("post_reset_place", place_pulse, 0);

        // Randomized game against the model.
        do_reset();
        for (int i = 0; i < 3000 && m_phase != 2; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    rm = C;
                2:       rm = C | (5'b1 << $urandom_range(0, 3));
                3:       rm = U | D;
                4:       rm = L | R;
                default: rm = 5'(5'b1 << $urandom_range(0, 3));
            endcase
            do_press(rm);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
